// File: rtl/shared_ocm_dp_arb.sv
// Dual-port shared on-chip memory with two Avalon-MM slaves, byte-lane writes,
// 1- or 2-cycle read latency, same-address write arbitration and zero-fill after reset.
module shared_ocm_dp_arb #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = 8,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest
);

  localparam int                BE_W      = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state_reg;
  logic              prio_reg;
  logic [ADDR_W-1:0] clr_addr_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] p_addr     [2];
  logic [BE_W-1:0]   p_be       [2];
  logic [DATA_W-1:0] p_wdata    [2];
  logic [DATA_W-1:0] p_rdata    [2];
  logic              p_wr       [2];
  logic              p_rd       [2];
  logic              p_in_range [2];
  logic              p_wait     [2];
  logic              p_wr_acc   [2];
  logic              p_rd_acc   [2];
  logic              p_rvalid   [2];

  assign p_addr[0]  = s1_address;
  assign p_addr[1]  = s2_address;
  assign p_be[0]    = s1_byteenable;
  assign p_be[1]    = s2_byteenable;
  assign p_wdata[0] = s1_writedata;
  assign p_wdata[1] = s2_writedata;
  // A cycle with both read and write asserted is a pure write.
  assign p_wr[0]    = s1_chipselect & s1_write;
  assign p_wr[1]    = s2_chipselect & s2_write;
  assign p_rd[0]    = s1_chipselect & s1_read & ~s1_write;
  assign p_rd[1]    = s2_chipselect & s2_read & ~s2_write;

  logic run, clearing, collision;
  assign run       = reset_n & (state_reg == ST_RUN);
  assign clearing  = reset_n & (state_reg == ST_CLEAR);
  assign collision = run & p_wr[0] & p_wr[1] & p_in_range[0] & (p_addr[0] == p_addr[1]);

  // The port not favoured by prio_reg stalls for the collision cycle only.
  assign p_wait[0] = ~run | (collision & prio_reg);
  assign p_wait[1] = ~run | (collision & ~prio_reg);

  assign s1_waitrequest   = p_wait[0];
  assign s2_waitrequest   = p_wait[1];
  assign s1_readdata      = p_rdata[0];
  assign s2_readdata      = p_rdata[1];
  assign s1_readdatavalid = p_rvalid[0];
  assign s2_readdatavalid = p_rvalid[1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_addr_reg <= '0;
      prio_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_addr_reg <= clr_addr_reg + 1'b1;
          if (clr_addr_reg == LAST_ADDR) state_reg <= ST_RUN;
        end
        ST_RUN: if (collision) prio_reg <= ~prio_reg;
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  // Port 1 write path doubles as the zero-fill path during CLEAR.
  logic              w0_en, w1_en;
  logic [ADDR_W-1:0] w0_addr;
  logic [BE_W-1:0]   w0_be;
  logic [DATA_W-1:0] w0_data;

  assign w0_en   = clearing | (p_wr_acc[0] & p_in_range[0]);
  assign w0_addr = clearing ? clr_addr_reg : p_addr[0];
  assign w0_be   = clearing ? '1 : p_be[0];
  assign w0_data = clearing ? '0 : p_wdata[0];
  assign w1_en   = p_wr_acc[1] & p_in_range[1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (w0_en && w0_be[b]) mem[w0_addr][b*8 +: 8] <= w0_data[b*8 +: 8];
      if (w1_en && p_be[1][b]) mem[p_addr[1]][b*8 +: 8] <= p_wdata[1][b*8 +: 8];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] rd_word;

      assign p_in_range[gi] = ({1'b0, p_addr[gi]} < DEPTH_X);
      assign p_wr_acc[gi]   = p_wr[gi] & ~p_wait[gi];
      assign p_rd_acc[gi]   = p_rd[gi] & ~p_wait[gi];
      assign rd_word        = p_in_range[gi] ? mem[p_addr[gi]] : '0;

      if (READ_LATENCY == 1) begin : g_lat1
        logic [DATA_W-1:0] rdata_reg;
        logic              rvalid_reg;

        always_ff @(posedge clk) begin
          if (!reset_n) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
          end else begin
            rvalid_reg <= p_rd_acc[gi];
            if (p_rd_acc[gi]) rdata_reg <= rd_word;
          end
        end
        assign p_rdata[gi]  = rdata_reg;
        assign p_rvalid[gi] = rvalid_reg;
      end else begin : g_lat2
        logic [DATA_W-1:0] stage_data_reg, rdata_reg;
        logic              stage_valid_reg, rvalid_reg;

        always_ff @(posedge clk) begin
          if (!reset_n) begin
            stage_data_reg  <= '0;
            stage_valid_reg <= 1'b0;
            rdata_reg       <= '0;
            rvalid_reg      <= 1'b0;
          end else begin
            stage_valid_reg <= p_rd_acc[gi];
            if (p_rd_acc[gi]) stage_data_reg <= rd_word;
            rvalid_reg <= stage_valid_reg;
            if (stage_valid_reg) rdata_reg <= stage_data_reg;
          end
        end
        assign p_rdata[gi]  = rdata_reg;
        assign p_rvalid[gi] = rvalid_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_shared_ocm_dp_arb.sv
// Directed bench: two instances (256 words / latency 1, 200 words / latency 2) share
// one stimulus stream; each is checked against hand-computed expectations.
module tb_shared_ocm_dp_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  s1_address, s2_address;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic        s1_chipselect, s1_read, s1_write;
  logic        s2_chipselect, s2_read, s2_write;
  logic [31:0] s1_writedata, s2_writedata;

  logic [31:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
  logic        a_rvalid1, a_rvalid2, b_rvalid1, b_rvalid2;
  logic        a_wait1, a_wait2, b_wait1, b_wait2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shared_ocm_dp_arb #(.DATA_W(32), .DEPTH(256), .ADDR_W(8), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .reset_n(reset_n),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(a_rdata1), .s1_readdatavalid(a_rvalid1), .s1_waitrequest(a_wait1),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(a_rdata2), .s2_readdatavalid(a_rvalid2), .s2_waitrequest(a_wait2)
  );

  shared_ocm_dp_arb #(.DATA_W(32), .DEPTH(200), .ADDR_W(8), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .reset_n(reset_n),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(b_rdata1), .s1_readdatavalid(b_rvalid1), .s1_waitrequest(b_wait1),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(b_rdata2), .s2_readdatavalid(b_rvalid2), .s2_waitrequest(b_wait2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
  endtask

  task automatic set_wr(input bit p, input logic [7:0] addr, input logic [31:0] d, input logic [3:0] be);
    if (!p) begin
      s1_address = addr; s1_writedata = d; s1_byteenable = be;
      s1_chipselect = 1'b1; s1_write = 1'b1; s1_read = 1'b0;
    end else begin
      s2_address = addr; s2_writedata = d; s2_byteenable = be;
      s2_chipselect = 1'b1; s2_write = 1'b1; s2_read = 1'b0;
    end
  endtask

  task automatic set_rd(input bit p, input logic [7:0] addr);
    if (!p) begin
      s1_address = addr; s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b0;
    end else begin
      s2_address = addr; s2_chipselect = 1'b1; s2_read = 1'b1; s2_write = 1'b0;
    end
  endtask

  task automatic wr(input bit p, input logic [7:0] addr, input logic [31:0] d, input logic [3:0] be);
    set_wr(p, addr, d, be);
    settle();
    check("wr_nowait", 32'({a_wait1, a_wait2, b_wait1, b_wait2}), 32'h0);
    clk_step();
    idle();
    $display("wr   port%0d addr %0d data %h be %b", p + 1, addr, d, be);
  endtask

  // Called after the acceptance edge: latency-1 instance is valid now, latency-2 one cycle later.
  task automatic check_read(input bit p, input logic [31:0] exp_a, input logic [31:0] exp_b);
    check("rd_a_valid_l1", 32'(p ? a_rvalid2 : a_rvalid1), 32'h1);
    check("rd_a_data",     p ? a_rdata2 : a_rdata1, exp_a);
    check("rd_b_early",    32'(p ? b_rvalid2 : b_rvalid1), 32'h0);
    clk_step();
    check("rd_a_pulse",    32'(p ? a_rvalid2 : a_rvalid1), 32'h0);
    check("rd_a_hold",     p ? a_rdata2 : a_rdata1, exp_a);
    check("rd_b_valid_l2", 32'(p ? b_rvalid2 : b_rvalid1), 32'h1);
    check("rd_b_data",     p ? b_rdata2 : b_rdata1, exp_b);
  endtask

  task automatic rd(input bit p, input logic [7:0] addr, input logic [31:0] exp_a, input logic [31:0] exp_b);
    set_rd(p, addr);
    clk_step();
    idle();
    $display("rd   port%0d addr %0d expect a=%h b=%h", p + 1, addr, exp_a, exp_b);
    check_read(p, exp_a, exp_b);
  endtask

  task automatic count_clear(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int i = 0; i < 600; i++) begin
      if (!a_wait1 && !b_wait1) break;
      if (a_wait1 && a_wait2) na++;
      if (b_wait1 && b_wait2) nb++;
      clk_step();
    end
  endtask

  initial begin
    int na, nb;
    reset_n = 1'b0;
    s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
    s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
    idle();
    repeat (3) clk_step();
    check("rst_wait",   32'({a_wait1, a_wait2, b_wait1, b_wait2}), 32'hF);
    check("rst_valid",  32'({a_rvalid1, a_rvalid2, b_rvalid1, b_rvalid2}), 32'h0);
    check("rst_rdata",  a_rdata1 | a_rdata2 | b_rdata1 | b_rdata2, 32'h0);

    reset_n = 1'b1;
    settle();
    count_clear(na, nb);
    check("clear_cycles_a", 32'(na), 32'd256);
    check("clear_cycles_b", 32'(nb), 32'd200);
    rd(0, 8'hFF, 32'h0, 32'h0);

    // byte-lane merge
    wr(1, 8'd5, 32'h11223344, 4'hF);
    wr(0, 8'd5, 32'hDEADBEEF, 4'b0101);
    rd(1, 8'd5, 32'h11AD33EF, 32'h11AD33EF);

    // first collision: port 1 wins, port 2 lands last
    set_wr(0, 8'd9, 32'hA, 4'hF);
    set_wr(1, 8'd9, 32'hB, 4'hF);
    settle();
    check("coll1_w1", 32'({a_wait1, b_wait1}), 32'h0);
    check("coll1_w2", 32'({a_wait2, b_wait2}), 32'h3);
    clk_step();
    s1_chipselect = 1'b0; s1_write = 1'b0;
    settle();
    check("coll1_w2_retry", 32'({a_wait2, b_wait2}), 32'h0);
    clk_step();
    idle();
    $display("coll port1/port2 addr 9 priority port1");
    rd(0, 8'd9, 32'hB, 32'hB);

    // repeat collision: priority has flipped to port 2
    set_wr(0, 8'd9, 32'hA, 4'hF);
    set_wr(1, 8'd9, 32'hB, 4'hF);
    settle();
    check("coll2_w1", 32'({a_wait1, b_wait1}), 32'h3);
    check("coll2_w2", 32'({a_wait2, b_wait2}), 32'h0);
    clk_step();
    s2_chipselect = 1'b0; s2_write = 1'b0;
    settle();
    check("coll2_w1_retry", 32'({a_wait1, b_wait1}), 32'h0);
    clk_step();
    idle();
    $display("coll port1/port2 addr 9 priority port2");
    rd(1, 8'd9, 32'hA, 32'hA);

    // third collision: priority back to port 1
    set_wr(0, 8'd9, 32'hC, 4'hF);
    set_wr(1, 8'd9, 32'hD, 4'hF);
    settle();
    check("coll3_w", 32'({a_wait1, b_wait1, a_wait2, b_wait2}), 32'h3);
    clk_step();
    s1_chipselect = 1'b0; s1_write = 1'b0;
    clk_step();
    idle();
    rd(0, 8'd9, 32'hD, 32'hD);

    // mixed write/read to the same address returns old data
    wr(0, 8'd3, 32'h77, 4'hF);
    set_wr(0, 8'd3, 32'h55, 4'hF);
    set_rd(1, 8'd3);
    settle();
    check("mixed_nowait", 32'({a_wait1, a_wait2, b_wait1, b_wait2}), 32'h0);
    clk_step();
    idle();
    $display("mix  port1 wr 0x55 / port2 rd addr 3");
    check_read(1, 32'h77, 32'h77);
    rd(0, 8'd3, 32'h55, 32'h55);

    // concurrent different addresses
    set_wr(0, 8'd20, 32'h01020304, 4'hF);
    set_wr(1, 8'd21, 32'h05060708, 4'hF);
    settle();
    check("conc_nowait", 32'({a_wait1, a_wait2, b_wait1, b_wait2}), 32'h0);
    clk_step();
    idle();
    rd(0, 8'd21, 32'h05060708, 32'h05060708);
    rd(1, 8'd20, 32'h01020304, 32'h01020304);

    // address 210: in range for the 256-word instance, out of range for the 200-word one
    wr(0, 8'd210, 32'h12345678, 4'hF);
    rd(0, 8'd210, 32'h12345678, 32'h0);
    rd(1, 8'd10, 32'h0, 32'h0);

    // reset during clear restarts it from address 0
    wr(1, 8'd150, 32'hCAFEF00D, 4'hF);
    rd(0, 8'd150, 32'hCAFEF00D, 32'hCAFEF00D);
    reset_n = 1'b0;
    clk_step();
    reset_n = 1'b1;
    repeat (100) clk_step();
    reset_n = 1'b0;
    clk_step();
    check("rst2_rdata", a_rdata1 | b_rdata1, 32'h0);
    check("rst2_wait", 32'({a_wait1, a_wait2, b_wait1, b_wait2}), 32'hF);
    reset_n = 1'b1;
    settle();
    count_clear(na, nb);
    check("reclear_cycles_a", 32'(na), 32'd256);
    check("reclear_cycles_b", 32'(nb), 32'd200);
    rd(1, 8'd150, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shared_ocm_dp_arb.md
Name: shared_ocm_dp_arb

Overview:
- Parametrised dual-port shared on-chip memory with two Avalon-MM slaves (s1, s2). Both share one clock.
- Successor to the fixed 256x32 bidirectional dual-port OCM used for inter-processor data exchange.
- New features: configurable width, depth and read latency; readdatavalid pipelining; waitrequest-based same-address write-collision arbitration with fair alternating priority; optional hardware zero-fill after reset.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 256, number of words; need not be a power of 2.
- ADDR_W, 8, address width; must equal clog2(DEPTH).
- READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = zero-fill the whole array after reset; 0 = contents untouched, enter RUN directly.

Ports:
- clk  in  1  single clock for both ports.
- reset_n  in  1  synchronous reset, active-low.
- s1_address  in  ADDR_W  port-1 word address.
- s1_byteenable  in  DATA_W/8  port-1 byte lane enables.
- s1_chipselect  in  1  port-1 select.
- s1_read  in  1  port-1 read request.
- s1_write  in  1  port-1 write request.
- s1_writedata  in  DATA_W  port-1 write data.
- s1_readdata  out  DATA_W  port-1 read data.
- s1_readdatavalid  out  1  port-1 read data valid.
- s1_waitrequest  out  1  port-1 stall.
- s2_address, s2_byteenable, s2_chipselect, s2_read, s2_write, s2_writedata, s2_readdata, s2_readdatavalid, s2_waitrequest: identical to s1_* for port 2.

Behaviour:
- Reset (reset_n=0 sampled on clk rising edge):
  - readdata=0, readdatavalid=0, read pipelines flushed.
  - prio=0 (port 1 wins the first collision).
  - clr_addr=0.
  - state=CLEAR if CLEAR_ON_RESET=1, else RUN.
  - Both waitrequests are 1 while reset_n=0.
- FSM states: CLEAR, RUN.
  - CLEAR: writes 0 (all bytes) to clr_addr each cycle and increments clr_addr. Both waitrequests are 1. Exits to RUN after writing DEPTH-1, so the clear takes exactly DEPTH cycles.
  - RUN: normal operation; waitrequest is 0 except on a collision.
  - Reset asserted mid-CLEAR restarts the clear at address 0.
- Request and accept rules, per port:
  - Request = chipselect & (read | write).
  - A request is accepted on a cycle where it is present and waitrequest=0.
  - If read and write are both asserted, the cycle is treated as a write; no readdatavalid is generated.
  - Masters hold all request signals while waitrequest=1.
- Writes: an accepted write updates only the byte lanes with byteenable=1, at the clock edge of acceptance.
- Reads:
  - readdatavalid pulses exactly READ_LATENCY cycles after acceptance.
  - Back-to-back reads sustain one per cycle.
  - readdata holds its last value when readdatavalid=0.
- Out-of-range address (>= DEPTH):
  - Write is accepted and dropped.
  - Read is accepted and returns 0 with the normal readdatavalid timing.
- Collision: both ports request a write to the same in-range address in the same RUN cycle.
  - Winner is port 1 if prio=0, port 2 if prio=1.
  - The loser's waitrequest is 1 combinationally that cycle.
  - The winner's write is accepted.
  - prio flips to favour the loser, so the loser wins any immediate repeat collision and starvation is impossible.
  - The loser's write is accepted on a following cycle, so it lands last.
  - prio changes only on collisions.
- Mixed read/write to the same address in the same cycle: no stall; the read returns the OLD data.
- Different addresses on the two ports: fully concurrent, no stalls.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=256: waitrequest stays 1 for 256 cycles after reset_n rises. Then s1 read of addr 0xFF gives readdata=0 with readdatavalid 1 cycle later.
- s1 write 0xDEADBEEF to addr 5 with byteenable=4'b0101, over prior 0x11223344, then s2 read addr 5: s2_readdata=0x11AD33EF, valid at READ_LATENCY (test both 1 and 2).
- Same-cycle writes to addr 9, s1=0xA, s2=0xB, prio=0: s2_waitrequest=1 for one cycle, final mem[9]=0xB. Repeat the collision: s1 stalls, final value written by s1.
- s1 write 0x55 and s2 read, same cycle, same addr 3 (old 0x77): no waitrequest, s2_readdata=0x77. The next read returns 0x55.
- DEPTH=200, ADDR_W=8: write to addr 210 leaves memory unchanged; read of addr 210 gives readdata=0 with readdatavalid asserted.
- reset_n pulsed low at clear cycle 100: clear restarts, waitrequest stays 1 for a further full 256 cycles; word 150, pre-filled, reads 0 afterwards.
